// File: rtl/sram_match_scheduler_pkg.sv
// Shared constants, widths and mode encodings for the SRAM matcher and its scheduler.
// Also holds the probe mapping and one-hot encoder used by the scheduler.
package sram_match_scheduler_pkg;

  localparam int PORT_NUM   = 16;
  localparam int SRAM_NUM   = 32;
  localparam int SRAM_IDX_W = 5;
  localparam int SPACE_W    = 11;
  localparam int PORT_W     = 4;

  typedef logic [SRAM_IDX_W-1:0] sram_idx_t;
  typedef logic [SPACE_W-1:0]    space_t;
  typedef logic [PORT_W-1:0]     port_idx_t;

  typedef enum logic [1:0] {
    MODE_STATIC   = 2'd0,
    MODE_SEMI     = 2'd1,
    MODE_DYNAMIC  = 2'd2,
    MODE_DYNAMIC2 = 2'd3
  } match_mode_e;

  // Each mapping keeps all 16 port indices distinct within any one cycle.
  function automatic sram_idx_t probe_index(input logic [1:0] mode,
                                            input sram_idx_t  phase,
                                            input port_idx_t  port);
    sram_idx_t idx;
    case (mode)
      MODE_STATIC: idx = {port, phase[0]};
      MODE_SEMI:   idx = {port[3], 4'(phase[3:0] + port)};
      default:     idx = phase + {port, 1'b0};
    endcase
    return idx;
  endfunction

  function automatic port_idx_t onehot_to_port(input logic [PORT_NUM-1:0] vec);
    port_idx_t r;
    r = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (vec[i]) r = r | port_idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_match_scheduler_if.sv
// Bundle between the per-port matchers (master) and the central scheduler (slave).
// Claims/releases flow in, per-port probe results and claim responses flow out.
interface sram_match_scheduler_if;
  import sram_match_scheduler_pkg::*;

  logic [1:0]                           match_mode;
  logic [SRAM_NUM-1:0][SPACE_W-1:0]     sram_free_space;
  logic [PORT_NUM-1:0]                  claim_valid;
  logic [PORT_NUM-1:0][SRAM_IDX_W-1:0]  claim_sram;
  logic [PORT_NUM-1:0]                  release_valid;
  logic [PORT_NUM-1:0][SRAM_IDX_W-1:0]  release_sram;
  logic [PORT_NUM-1:0][SRAM_IDX_W-1:0]  probe_sram;
  logic [PORT_NUM-1:0]                  probe_accessible;
  logic [PORT_NUM-1:0][SPACE_W-1:0]     probe_free_space;
  logic [PORT_NUM-1:0]                  claim_ack;
  logic [PORT_NUM-1:0]                  claim_nack;
  logic [SRAM_NUM-1:0]                  sram_occupied;

  modport master (
    output match_mode, sram_free_space, claim_valid, claim_sram,
           release_valid, release_sram,
    input  probe_sram, probe_accessible, probe_free_space,
           claim_ack, claim_nack, sram_occupied
  );

  modport slave (
    input  match_mode, sram_free_space, claim_valid, claim_sram,
           release_valid, release_sram,
    output probe_sram, probe_accessible, probe_free_space,
           claim_ack, claim_nack, sram_occupied
  );

endinterface

// File: rtl/sram_claim_arbiter.sv
// 16-way round-robin arbiter: first requester at or after rr_ptr wins, one-hot grant.
// Purely combinational; no backpressure.
module sram_claim_arbiter
  import sram_match_scheduler_pkg::*;
(
  input  logic [PORT_NUM-1:0] req,
  input  port_idx_t           rr_ptr,
  output logic [PORT_NUM-1:0] grant
);

  port_idx_t cand;
  logic      found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      cand = rr_ptr + port_idx_t'(i);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_match_scheduler.sv
// Assigns each port a distinct SRAM to probe per cycle and arbitrates ownership claims.
// Latency: probe and claim responses one cycle after sampling; no backpressure (claims always answered).
module sram_match_scheduler
  import sram_match_scheduler_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  sram_match_scheduler_if.slave bus
);

  sram_idx_t                           phase;
  logic [1:0]                          mode_q;
  port_idx_t                           rr_ptr;
  port_idx_t                           rr_next;
  logic                                rr_found;
  port_idx_t                           rr_cand;
  logic [SRAM_NUM-1:0]                 occupied;
  logic [SRAM_NUM-1:0][PORT_W-1:0]     owner;

  logic [PORT_NUM-1:0][SRAM_IDX_W-1:0] probe_idx;
  logic [PORT_NUM-1:0]                 probe_acc_next;
  logic [PORT_NUM-1:0][SRAM_IDX_W-1:0] probe_sram_q;
  logic [PORT_NUM-1:0]                 probe_acc_q;
  logic [PORT_NUM-1:0][SPACE_W-1:0]    probe_fs_q;

  logic [SRAM_NUM-1:0][PORT_NUM-1:0]   req;
  logic [SRAM_NUM-1:0][PORT_NUM-1:0]   free_req;
  logic [SRAM_NUM-1:0][PORT_NUM-1:0]   grant;
  logic [SRAM_NUM-1:0]                 release_hit;
  logic [PORT_NUM-1:0]                 win;
  logic [PORT_NUM-1:0]                 ack_next;
  logic [PORT_NUM-1:0]                 nack_next;
  logic [PORT_NUM-1:0]                 ack_q;
  logic [PORT_NUM-1:0]                 nack_q;

  always_comb begin
    probe_idx      = '0;
    probe_acc_next = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      probe_idx[p]      = probe_index(bus.match_mode, phase, port_idx_t'(p));
      probe_acc_next[p] = ~occupied[probe_idx[p]] |
                          (owner[probe_idx[p]] == port_idx_t'(p));
    end
  end

  always_comb begin
    req = '0;
    for (int s = 0; s < SRAM_NUM; s++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        req[s][p] = bus.claim_valid[p] && (bus.claim_sram[p] == sram_idx_t'(s));
      end
    end
  end

  // Only unowned SRAMs go through arbitration; owned ones resolve by owner match.
  for (genvar s = 0; s < SRAM_NUM; s++) begin : g_arb
    assign free_req[s] = req[s] & {PORT_NUM{~occupied[s]}};
    sram_claim_arbiter u_arb (
      .req    (free_req[s]),
      .rr_ptr (rr_ptr),
      .grant  (grant[s])
    );
  end

  always_comb begin
    win      = '0;
    ack_next = '0;
    for (int s = 0; s < SRAM_NUM; s++) begin
      win = win | grant[s];
      if (occupied[s] && req[s][owner[s]]) ack_next[owner[s]] = 1'b1;
    end
    ack_next  = ack_next | win;
    nack_next = bus.claim_valid & ~ack_next;
  end

  always_comb begin
    rr_next  = rr_ptr;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      rr_cand = rr_ptr + port_idx_t'(i);
      if (!rr_found && win[rr_cand]) begin
        rr_next  = rr_cand + 4'd1;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    release_hit = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (bus.release_valid[p] && occupied[bus.release_sram[p]] &&
          owner[bus.release_sram[p]] == port_idx_t'(p))
        release_hit[bus.release_sram[p]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase        <= '0;
      mode_q       <= '0;
      rr_ptr       <= '0;
      occupied     <= '0;
      owner        <= '0;
      probe_sram_q <= '0;
      probe_acc_q  <= '0;
      probe_fs_q   <= '0;
      ack_q        <= '0;
      nack_q       <= '0;
    end else begin
      mode_q <= bus.match_mode;
      phase  <= (bus.match_mode != mode_q) ? '0 : phase + 5'd1;
      rr_ptr <= rr_next;
      ack_q  <= ack_next;
      nack_q <= nack_next;
      // A grant needs a free SRAM and a release an owned one, so they never collide.
      for (int s = 0; s < SRAM_NUM; s++) begin
        if (|grant[s]) begin
          occupied[s] <= 1'b1;
          owner[s]    <= onehot_to_port(grant[s]);
        end else if (release_hit[s]) begin
          occupied[s] <= 1'b0;
        end
      end
      for (int p = 0; p < PORT_NUM; p++) begin
        probe_sram_q[p] <= probe_idx[p];
        probe_acc_q[p]  <= probe_acc_next[p];
        probe_fs_q[p]   <= bus.sram_free_space[probe_idx[p]];
      end
    end
  end

  assign bus.probe_sram       = probe_sram_q;
  assign bus.probe_accessible = probe_acc_q;
  assign bus.probe_free_space = probe_fs_q;
  assign bus.claim_ack        = ack_q;
  assign bus.claim_nack       = nack_q;
  assign bus.sram_occupied    = occupied;

endmodule
